sc_detector_ctrl: RTL and testbench
===================================

Name: sc_detector_ctrl

Overview:
- Control sequencer for the Schmidl-Cox detector datapath, sitting between the RFNoC register interface and the detector.
- Latches a software configuration (threshold, packet length, output select, timeout) and drives it into the detector as a stable set.
- Issues timed clear pulses to the detector and arms it in single-shot or continuous mode.
- Counts detected packets and watchdog timeouts; raises sticky status flags.

Parameters:
CLEAR_CYCLES, 2, cycles det_clear is held high per clear sequence (>=1)
TO_CNT_WIDTH, 16, width of timeout_count (saturating)

Ports:
clk  in  1  block clock
reset  in  1  synchronous, active-high reset
cfg_threshold  in  32  detection threshold, captured on accepted cmd_arm
cfg_packet_length  in  32  samples forwarded per detection, captured on accepted cmd_arm
cfg_output_select  in  2  detector output mux select, captured on accepted cmd_arm
cfg_timeout  in  32  watchdog length in samples; 0 disables the watchdog
cmd_arm  in  1  one-cycle pulse: latch cfg_*, clear the detector, then arm
cmd_continuous  in  1  sampled with cmd_arm: 1 = continuous mode, 0 = single-shot
cmd_disarm  in  1  one-cycle pulse: return to IDLE
cmd_clear_stats  in  1  one-cycle pulse: zero pkt_count, timeout_count and sticky flags
sample_strobe  in  1  metric sample accepted by the detector (m_tvalid & m_tready)
end_of_ofdm_packet  in  1  detector last-forwarded-sample pulse
det_threshold  out  32  registered threshold to the detector
det_packet_length  out  32  registered packet length to the detector
det_output_select  out  2  registered output select to the detector
det_clear  out  1  clear to the detector
armed  out  1  high in the ARMED state
pkt_count  out  32  packets detected, saturating
timeout_count  out  TO_CNT_WIDTH  watchdog expiries, saturating
status_done  out  1  sticky: single-shot packet completed
status_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - Exception: det_clear = 1 during reset and deasserts on the first cycle after reset.
- States: IDLE, CLEARING, ARMED.
- IDLE:
  - armed = 0; det_clear = 0; events are ignored.
  - Accepted cmd_arm → capture all cfg_* into the det_* registers, mode and timeout shadow, on the same edge; go to CLEARING.
- CLEARING:
  - det_clear = 1 for exactly CLEAR_CYCLES cycles, then go to ARMED.
  - sample_strobe and end_of_ofdm_packet are ignored.
  - cmd_arm restarts the clear with a fresh capture.
- ARMED:
  - armed = 1; the watchdog counter (32-bit, zeroed on entry) increments on each sample_strobe.
  - end_of_ofdm_packet → pkt_count += 1 and watchdog zeroed.
    - Continuous mode: stay in ARMED.
    - Single-shot mode: status_done = 1, go to IDLE.
  - Watchdog expiry: timeout shadow != 0, sample_strobe, and counter == timeout-1.
    - Effect: timeout_count += 1, status_timeout = 1, watchdog zeroed.
    - Continuous mode: go to CLEARING (re-clear the detector without a new cfg capture).
    - Single-shot mode: go to IDLE.
  - cmd_arm while ARMED → re-capture cfg_* and go to CLEARING; counters are kept.
- Command priority, same cycle: cmd_disarm > cmd_arm. cmd_disarm from any state → IDLE, det_clear = 0 next cycle.
- Same-cycle end_of_ofdm_packet and watchdog expiry: the packet wins; no timeout is counted.
- cmd_clear_stats:
  - Acts in any state and does not change the state.
  - If a count event occurs in the same cycle, the clear wins: counter = 0.
- Counters saturate at all-ones and never wrap.
- The det_* registers change only on an accepted cmd_arm. They are stable for the whole detection.
- Latency:
  - Command → state/outputs: 1 cycle.
  - Event → counters/flags: 1 cycle.
- Reset mid-operation aborts any clear or arm sequence immediately; counters are zeroed.

Decomposition:
- Shared package sc_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, CLEARING, ARMED}.
  - Output-select constants OSEL_SIGNAL = 2'b00, OSEL_GATED = 2'b01, OSEL_METRIC_MSB = 2'b10, OSEL_METRIC_LSB = 2'b11.
- One natural sub-module: sat_counter (parameterised width, inc and clr inputs, clr priority), instantiated for pkt_count and timeout_count.

Test Plan:
- Reset release, then cmd_arm with threshold = 0x1000, length = 640, osel = 01, CLEAR_CYCLES = 2:
  - det_* update on the next edge; det_clear high exactly 2 cycles; then armed = 1.
- Single-shot mode, end_of_ofdm_packet pulse while ARMED → pkt_count = 1, status_done = 1, armed = 0 one cycle later.
- Continuous mode, cfg_timeout = 100, no packet, 100 sample_strobes:
  - After the 100th strobe: timeout_count = 1 and status_timeout = 1.
  - 2 det_clear cycles follow, then re-arm.
  - Repeat 3 times → timeout_count = 3.
- end_of_ofdm_packet on the same cycle as the 100th strobe → pkt_count += 1, timeout_count unchanged, watchdog zeroed.
- cmd_arm and cmd_disarm in the same cycle while ARMED → IDLE, det_* unchanged.
- Counter limits:
  - pkt_count preloaded to 0xFFFFFFFF plus one packet → stays 0xFFFFFFFF.
  - cmd_clear_stats coincident with a packet → pkt_count = 0.

Source files
------------

// File: rtl/sc_ctrl_pkg.sv
// Shared types and constants for the Schmidl-Cox detector control sequencer.
package sc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEARING = 2'd1,
    ARMED    = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] OSEL_SIGNAL     = 2'b00;
  localparam logic [1:0] OSEL_GATED      = 2'b01;
  localparam logic [1:0] OSEL_METRIC_MSB = 2'b10;
  localparam logic [1:0] OSEL_METRIC_LSB = 2'b11;

endpackage

// File: rtl/sc_detector_ctrl_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sc_detector_ctrl.sv
// Control sequencer for the Schmidl-Cox detector: latches configuration,
// issues timed clears, arms the detector and keeps packet/timeout statistics.
module sc_detector_ctrl
  import sc_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES = 2,
  parameter int TO_CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             cfg_threshold,
  input  logic [31:0]             cfg_packet_length,
  input  logic [1:0]              cfg_output_select,
  input  logic [31:0]             cfg_timeout,
  input  logic                    cmd_arm,
  input  logic                    cmd_continuous,
  input  logic                    cmd_disarm,
  input  logic                    cmd_clear_stats,
  input  logic                    sample_strobe,
  input  logic                    end_of_ofdm_packet,
  output logic [31:0]             det_threshold,
  output logic [31:0]             det_packet_length,
  output logic [1:0]              det_output_select,
  output logic                    det_clear,
  output logic                    armed,
  output logic [31:0]             pkt_count,
  output logic [TO_CNT_WIDTH-1:0] timeout_count,
  output logic                    status_done,
  output logic                    status_timeout
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  ctrl_state_t state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   threshold_q, length_q, timeout_q;
  logic [1:0]    osel_q;
  logic          continuous_q, det_clear_q, done_q, to_flag_q;
  logic          capture, pkt_inc, to_inc, done_set, expiry;

  assign expiry = (timeout_q != 32'd0) && sample_strobe && (wd_q == timeout_q - 32'd1);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wd_d      = '0;
    capture   = 1'b0;
    pkt_inc   = 1'b0;
    to_inc    = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      CLEARING: begin
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
          state_d = ARMED;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      ARMED: begin
        wd_d = wd_q;
        // A packet ending on the expiry strobe counts as a packet, not a timeout.
        if (end_of_ofdm_packet) begin
          pkt_inc = 1'b1;
          wd_d    = '0;
          if (!continuous_q) begin
            done_set = 1'b1;
            state_d  = IDLE;
          end
        end else if (expiry) begin
          to_inc    = 1'b1;
          wd_d      = '0;
          clr_cnt_d = '0;
          state_d   = continuous_q ? CLEARING : IDLE;
        end else if (sample_strobe) begin
          wd_d = wd_q + 32'd1;
        end
      end
      default: ;
    endcase
    if (cmd_arm && !cmd_disarm) begin
      capture   = 1'b1;
      state_d   = CLEARING;
      clr_cnt_d = '0;
      wd_d      = '0;
    end
    if (cmd_disarm) begin
      state_d = IDLE;
      wd_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      wd_q         <= '0;
      threshold_q  <= '0;
      length_q     <= '0;
      osel_q       <= '0;
      timeout_q    <= '0;
      continuous_q <= 1'b0;
      det_clear_q  <= 1'b1;
      done_q       <= 1'b0;
      to_flag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wd_q        <= wd_d;
      det_clear_q <= (state_d == CLEARING);
      if (capture) begin
        threshold_q  <= cfg_threshold;
        length_q     <= cfg_packet_length;
        osel_q       <= cfg_output_select;
        timeout_q    <= cfg_timeout;
        continuous_q <= cmd_continuous;
      end
      if (cmd_clear_stats) begin
        done_q    <= 1'b0;
        to_flag_q <= 1'b0;
      end else begin
        if (done_set) done_q <= 1'b1;
        if (to_inc) to_flag_q <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_pkt_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cmd_clear_stats),
    .inc_i  (pkt_inc),
    .count_o(pkt_count)
  );

  sat_counter #(.WIDTH(TO_CNT_WIDTH)) u_to_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cmd_clear_stats),
    .inc_i  (to_inc),
    .count_o(timeout_count)
  );

  assign det_threshold     = threshold_q;
  assign det_packet_length = length_q;
  assign det_output_select = osel_q;
  assign det_clear         = det_clear_q;
  assign armed             = (state_q == ARMED);
  assign status_done       = done_q;
  assign status_timeout    = to_flag_q;

endmodule

// File: tb/tb_sc_detector_ctrl.sv
// Directed bench for sc_detector_ctrl with hand-computed expectations.
module tb_sc_detector_ctrl;
  import sc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_threshold, cfg_packet_length, cfg_timeout;
  logic [1:0]  cfg_output_select;
  logic        cmd_arm, cmd_continuous, cmd_disarm, cmd_clear_stats;
  logic        sample_strobe, end_of_ofdm_packet;
  logic [31:0] det_threshold, det_packet_length, pkt_count;
  logic [1:0]  det_output_select;
  logic        det_clear, armed, status_done, status_timeout;
  logic [15:0] timeout_count;

  logic        sc_clr, sc_inc;
  logic [3:0]  sc_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  sc_detector_ctrl #(.CLEAR_CYCLES(2), .TO_CNT_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_threshold     (cfg_threshold),
    .cfg_packet_length (cfg_packet_length),
    .cfg_output_select (cfg_output_select),
    .cfg_timeout       (cfg_timeout),
    .cmd_arm           (cmd_arm),
    .cmd_continuous    (cmd_continuous),
    .cmd_disarm        (cmd_disarm),
    .cmd_clear_stats   (cmd_clear_stats),
    .sample_strobe     (sample_strobe),
    .end_of_ofdm_packet(end_of_ofdm_packet),
    .det_threshold     (det_threshold),
    .det_packet_length (det_packet_length),
    .det_output_select (det_output_select),
    .det_clear         (det_clear),
    .armed             (armed),
    .pkt_count         (pkt_count),
    .timeout_count     (timeout_count),
    .status_done       (status_done),
    .status_timeout    (status_timeout)
  );

  // Small-width counter instance to reach saturation quickly.
  sat_counter #(.WIDTH(4)) u_sat (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (sc_clr),
    .inc_i  (sc_inc),
    .count_o(sc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] thr, input logic [31:0] len,
                         input logic [1:0] osel, input logic [31:0] to, input logic cont);
    cfg_threshold     = thr;
    cfg_packet_length = len;
    cfg_output_select = osel;
    cfg_timeout       = to;
    cmd_continuous    = cont;
  endtask

  task automatic arm_pulse();
    cmd_arm = 1'b1;
    step();
    cmd_arm = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      step();
    end
    sample_strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_arm = 0; cmd_disarm = 0; cmd_clear_stats = 0;
    sample_strobe = 0; end_of_ofdm_packet = 0;
    sc_clr = 0; sc_inc = 0;
    set_cfg(32'h0, 32'h0, OSEL_SIGNAL, 32'h0, 1'b0);
    repeat (3) step();
    check("rst_det_clear", det_clear, 1);
    check("rst_armed", armed, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_to", timeout_count, 0);
    check("rst_thr", det_threshold, 0);
    reset = 1'b0;
    step();
    check("post_rst_det_clear", det_clear, 0);

    // Single-shot arm and packet
    set_cfg(32'h1000, 32'd640, OSEL_GATED, 32'd0, 1'b0);
    arm_pulse();
    check("arm_thr", det_threshold, 32'h1000);
    check("arm_len", det_packet_length, 32'd640);
    check("arm_osel", det_output_select, OSEL_GATED);
    check("clr1", det_clear, 1);
    check("clr1_armed", armed, 0);
    step();
    check("clr2", det_clear, 1);
    step();
    check("clr_done", det_clear, 0);
    check("armed", armed, 1);
    end_of_ofdm_packet = 1'b1;
    step();
    end_of_ofdm_packet = 1'b0;
    check("ss_pkt", pkt_count, 1);
    check("ss_done", status_done, 1);
    check("ss_armed", armed, 0);

    // Continuous mode watchdog: three expiries
    set_cfg(32'h2000, 32'd320, OSEL_METRIC_MSB, 32'd100, 1'b1);
    arm_pulse();
    check("c_thr", det_threshold, 32'h2000);
    step();
    step();
    check("c_armed", armed, 1);
    for (int r = 0; r < 3; r++) begin
      strobes(99);
      check("to_pre", timeout_count, r);
      strobes(1);
      check("to_cnt", timeout_count, r + 1);
      check("to_flag", status_timeout, 1);
      check("to_reclr1", det_clear, 1);
      check("to_unarmed", armed, 0);
      step();
      check("to_reclr2", det_clear, 1);
      step();
      check("to_rearm", armed, 1);
      check("to_rearm_clr", det_clear, 0);
    end
    check("to_thr_kept", det_threshold, 32'h2000);

    // Packet coincident with the expiring strobe
    strobes(99);
    sample_strobe = 1'b1;
    end_of_ofdm_packet = 1'b1;
    step();
    sample_strobe = 1'b0;
    end_of_ofdm_packet = 1'b0;
    check("co_pkt", pkt_count, 2);
    check("co_to", timeout_count, 3);
    check("co_armed", armed, 1);
    strobes(99);
    check("co_wd_zeroed", timeout_count, 3);
    check("co_still_armed", armed, 1);

    // Arm and disarm together
    set_cfg(32'h3000, 32'd100, OSEL_METRIC_LSB, 32'd0, 1'b0);
    cmd_arm = 1'b1;
    cmd_disarm = 1'b1;
    step();
    cmd_arm = 1'b0;
    cmd_disarm = 1'b0;
    check("ad_armed", armed, 0);
    check("ad_clear", det_clear, 0);
    check("ad_thr", det_threshold, 32'h2000);
    check("ad_osel", det_output_select, OSEL_METRIC_MSB);

    // Events ignored while clearing; clear_stats beats a packet
    arm_pulse();
    end_of_ofdm_packet = 1'b1;
    step();
    end_of_ofdm_packet = 1'b0;
    check("clr_ign_pkt", pkt_count, 2);
    step();
    check("cs_armed", armed, 1);
    end_of_ofdm_packet = 1'b1;
    cmd_clear_stats = 1'b1;
    step();
    end_of_ofdm_packet = 1'b0;
    cmd_clear_stats = 1'b0;
    check("cs_pkt", pkt_count, 0);
    check("cs_to", timeout_count, 0);
    check("cs_done", status_done, 0);
    check("cs_toflag", status_timeout, 0);
    check("cs_idle", armed, 0);

    // Saturation on a 4-bit counter
    sc_inc = 1'b1;
    repeat (17) step();
    sc_inc = 1'b0;
    check("sat_hold", sc_count, 4'hF);
    sc_inc = 1'b1;
    sc_clr = 1'b1;
    step();
    sc_inc = 1'b0;
    sc_clr = 1'b0;
    check("sat_clr_wins", sc_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
